// File: rtl/wb_stage_if.sv
// MS -> WS pipeline handshake: valid/bus from the memory stage, allowin back from writeback.
interface wb_stage_if;
    logic        ms_to_ws_valid;
    logic [87:0] ms_to_ws_bus;
    logic        ws_allowin;

    modport master (output ms_to_ws_valid, output ms_to_ws_bus, input ws_allowin);
    modport slave  (input ms_to_ws_valid, input ms_to_ws_bus, output ws_allowin);
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: retires one instruction per cycle into the GPR file, commits
// exceptions/ERET to cp0, and drives flush/redirect, forwarding and debug trace.
module wb_stage #(
    parameter logic [31:0] EXC_ENTRY = 32'hbfc00380
) (
    input  logic         clk,
    input  logic         reset,
    wb_stage_if.slave    ms,
    input  logic [31:0]  cp0_rdata_bus,
    input  logic [31:0]  cp0_EPC_bus,
    output logic [78:0]  ws_to_cp0_bus,
    output logic         ws_to_cp0_valid,
    output logic         ws_mtc0_we,
    output logic         ws_flush,
    output logic [31:0]  ws_flush_pc,
    output logic         rf_we,
    output logic [4:0]   rf_waddr,
    output logic [31:0]  rf_wdata,
    output logic         ws_fwd_valid,
    output logic [4:0]   ws_fwd_dest,
    output logic [31:0]  ws_fwd_data,
    output logic [31:0]  debug_wb_pc,
    output logic [3:0]   debug_wb_rf_wen,
    output logic [4:0]   debug_wb_rf_wnum,
    output logic [31:0]  debug_wb_rf_wdata
);

    typedef struct packed {
        logic [7:0]  cp0_addr;
        logic        is_eret;
        logic        is_mfc0;
        logic        is_mtc0;
        logic        bd;
        logic [4:0]  excode;
        logic        excp;
        logic [31:0] result;
        logic [4:0]  dest;
        logic        gr_we;
        logic [31:0] pc;
    } ms_ws_bus_t;

    logic       ws_valid;
    logic       ws_ready_go;
    logic       ws_allowin;
    ms_ws_bus_t ws_bus;

    logic exc;
    logic ert;
    logic mtc;

    assign ws_ready_go   = 1'b1;
    assign ws_allowin    = !ws_valid || ws_ready_go;
    assign ms.ws_allowin = ws_allowin;

    // An instruction arriving while the retiring one flushes is dropped here.
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid <= 1'b0;
        end else if (ws_allowin) begin
            ws_valid <= ms.ms_to_ws_valid && !ws_flush;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_bus <= '0;
        end else if (ms.ms_to_ws_valid && ws_allowin) begin
            ws_bus <= ms.ms_to_ws_bus;
        end
    end

    // Exception wins over eret/mtc0 so a faulting instruction never updates state.
    assign exc = ws_valid && ws_bus.excp;
    assign ert = ws_valid && ws_bus.is_eret && !ws_bus.excp;
    assign mtc = ws_valid && ws_bus.is_mtc0 && !ws_bus.excp;

    assign rf_we    = ws_valid && ws_bus.gr_we && !ws_bus.excp && !ws_bus.is_eret;
    assign rf_waddr = ws_bus.dest;
    assign rf_wdata = ws_bus.is_mfc0 ? cp0_rdata_bus : ws_bus.result;

    assign ws_to_cp0_bus   = {ert, ws_bus.cp0_addr, ws_bus.result, ws_bus.excode, ws_bus.pc, ws_bus.bd};
    assign ws_to_cp0_valid = exc;
    assign ws_mtc0_we      = mtc;

    assign ws_flush    = exc || ert;
    assign ws_flush_pc = exc ? EXC_ENTRY : (ert ? cp0_EPC_bus : EXC_ENTRY);

    assign ws_fwd_valid = rf_we;
    assign ws_fwd_dest  = ws_bus.dest;
    assign ws_fwd_data  = rf_wdata;

    assign debug_wb_pc       = ws_valid ? ws_bus.pc : '0;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = ws_bus.dest;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Directed vector bench for wb_stage: table of retire cases plus reset corner sequences.
module tb_wb_stage;

    localparam logic [31:0] E = 32'hbfc00380;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cp0_rdata_bus = '0;
    logic [31:0] cp0_EPC_bus = '0;
    logic [78:0] ws_to_cp0_bus;
    logic        ws_to_cp0_valid, ws_mtc0_we, ws_flush, rf_we, ws_fwd_valid;
    logic [31:0] ws_flush_pc, rf_wdata, ws_fwd_data, debug_wb_pc, debug_wb_rf_wdata;
    logic [4:0]  rf_waddr, ws_fwd_dest, debug_wb_rf_wnum;
    logic [3:0]  debug_wb_rf_wen;

    int checks = 0;
    int errors = 0;

    wb_stage_if ms_if ();

    wb_stage #(.EXC_ENTRY(E)) dut (
        .clk               (clk),
        .reset             (reset),
        .ms                (ms_if.slave),
        .cp0_rdata_bus     (cp0_rdata_bus),
        .cp0_EPC_bus       (cp0_EPC_bus),
        .ws_to_cp0_bus     (ws_to_cp0_bus),
        .ws_to_cp0_valid   (ws_to_cp0_valid),
        .ws_mtc0_we        (ws_mtc0_we),
        .ws_flush          (ws_flush),
        .ws_flush_pc       (ws_flush_pc),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .ws_fwd_valid      (ws_fwd_valid),
        .ws_fwd_dest       (ws_fwd_dest),
        .ws_fwd_data       (ws_fwd_data),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, excp, eret, mfc0, mtc0, bd;
        logic [4:0]  excode;
        logic [7:0]  addr;
        logic [31:0] result;
        logic [4:0]  dest;
        logic        gr_we;
        logic [31:0] pc, rdata, epc;
        logic        e_rf_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_cp0v, e_mtc, e_flush, e_eflush;
        logic [31:0] e_fpc, e_dpc;
        logic [7:0]  e_caddr;
        logic [31:0] e_cwdata;
        logic [4:0]  e_cexc;
        logic [31:0] e_cpc;
        logic        e_cbd;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(
        input logic v, excp, eret, mfc0, mtc0, bd, input logic [4:0] excode,
        input logic [7:0] addr, input logic [31:0] result, input logic [4:0] dest,
        input logic gr_we, input logic [31:0] pc, rdata, epc,
        input logic e_rf_we, input logic [4:0] e_waddr, input logic [31:0] e_wdata,
        input logic e_cp0v, e_mtc, e_flush, e_eflush, input logic [31:0] e_fpc, e_dpc,
        input logic [7:0] e_caddr, input logic [31:0] e_cwdata, input logic [4:0] e_cexc,
        input logic [31:0] e_cpc, input logic e_cbd);
        vec_t r;
        r.v = v; r.excp = excp; r.eret = eret; r.mfc0 = mfc0; r.mtc0 = mtc0; r.bd = bd;
        r.excode = excode; r.addr = addr; r.result = result; r.dest = dest; r.gr_we = gr_we;
        r.pc = pc; r.rdata = rdata; r.epc = epc;
        r.e_rf_we = e_rf_we; r.e_waddr = e_waddr; r.e_wdata = e_wdata;
        r.e_cp0v = e_cp0v; r.e_mtc = e_mtc; r.e_flush = e_flush; r.e_eflush = e_eflush;
        r.e_fpc = e_fpc; r.e_dpc = e_dpc; r.e_caddr = e_caddr; r.e_cwdata = e_cwdata;
        r.e_cexc = e_cexc; r.e_cpc = e_cpc; r.e_cbd = e_cbd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [78:0] act, input logic [78:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_ms(input logic v, excp, eret, mfc0, mtc0, bd, input logic [4:0] excode,
                            input logic [7:0] addr, input logic [31:0] result,
                            input logic [4:0] dest, input logic gr_we, input logic [31:0] pc);
        ms_if.ms_to_ws_valid = v;
        ms_if.ms_to_ws_bus   = {addr, eret, mfc0, mtc0, bd, excode, excp, result, dest, gr_we, pc};
    endtask

    initial begin
        // Retire sequence; ws_valid history makes order significant (flush drops the next input).
        vecs[0]  = mk(1,0,0,0,0,0,5'h00,8'h00,32'h1234,5'd3,1,32'hbfc00000,32'h0,32'h0,       1,5'd3,32'h1234, 0,0,0,0, E,32'hbfc00000, 8'h00,32'h1234,5'h00,32'hbfc00000,0);
        vecs[1]  = vecs[0];
        vecs[2]  = vecs[0];
        vecs[3]  = mk(1,1,0,0,0,1,5'h08,8'h00,32'h5555,5'd7,1,32'hbfc00104,32'h0,32'h0,       0,5'd7,32'h5555, 1,0,1,0, E,32'hbfc00104, 8'h00,32'h5555,5'h08,32'hbfc00104,1);
        vecs[4]  = mk(1,0,0,0,0,0,5'h00,8'h00,32'h99,5'd5,1,32'hbfc00108,32'h0,32'h0,         0,5'd5,32'h99,   0,0,0,0, E,32'h0,        8'h00,32'h99,5'h00,32'hbfc00108,0);
        vecs[5]  = mk(1,0,1,0,0,0,5'h00,8'h00,32'h0,5'd0,0,32'hbfc00110,32'h0,32'hbfc00200,   0,5'd0,32'h0,    0,0,1,1, 32'hbfc00200,32'hbfc00110, 8'h00,32'h0,5'h00,32'hbfc00110,0);
        vecs[6]  = mk(0,0,0,0,0,0,5'h00,8'h00,32'h0,5'd0,0,32'h0,32'h0,32'hbfc00200,          0,5'd0,32'h0,    0,0,0,0, E,32'h0,        8'h00,32'h0,5'h00,32'hbfc00110,0);
        vecs[7]  = mk(1,0,0,0,1,0,5'h00,8'h60,32'hff01,5'd0,0,32'hbfc00120,32'h0,32'h0,       0,5'd0,32'hff01, 0,1,0,0, E,32'hbfc00120, 8'h60,32'hff01,5'h00,32'hbfc00120,0);
        vecs[8]  = mk(1,0,0,1,0,0,5'h00,8'h60,32'h0,5'd4,1,32'hbfc00124,32'h0000ff01,32'h0,   1,5'd4,32'hff01, 0,0,0,0, E,32'hbfc00124, 8'h60,32'h0,5'h00,32'hbfc00124,0);
        vecs[9]  = mk(1,1,0,0,1,0,5'h0a,8'h60,32'habcd,5'd0,0,32'hbfc00130,32'h0,32'h0,       0,5'd0,32'habcd, 1,0,1,0, E,32'hbfc00130, 8'h60,32'habcd,5'h0a,32'hbfc00130,0);
        vecs[10] = mk(0,0,0,0,0,0,5'h00,8'h00,32'h0,5'd0,0,32'h0,32'h0,32'h0,                 0,5'd0,32'habcd, 0,0,0,0, E,32'h0,        8'h60,32'habcd,5'h0a,32'hbfc00130,0);
        vecs[11] = mk(1,0,0,0,0,0,5'h00,8'h00,32'h77,5'd0,1,32'hbfc00140,32'h0,32'h0,         1,5'd0,32'h77,   0,0,0,0, E,32'hbfc00140, 8'h00,32'h77,5'h00,32'hbfc00140,0);
        vecs[12] = mk(1,1,1,0,0,0,5'h00,8'h00,32'h0,5'd0,0,32'hbfc00150,32'h0,32'hbfc00200,   0,5'd0,32'h0,    1,0,1,0, E,32'hbfc00150, 8'h00,32'h0,5'h00,32'hbfc00150,0);
        vecs[13] = mk(1,0,0,0,0,0,5'h00,8'h00,32'h88,5'd9,1,32'hbfc00160,32'h0,32'h0,         0,5'd9,32'h88,   0,0,0,0, E,32'h0,        8'h00,32'h88,5'h00,32'hbfc00160,0);
        vecs[14] = mk(1,0,0,0,0,0,5'h00,8'h00,32'h88,5'd9,1,32'hbfc00164,32'h0,32'h0,         1,5'd9,32'h88,   0,0,0,0, E,32'hbfc00164, 8'h00,32'h88,5'h00,32'hbfc00164,0);

        drive_ms(0,0,0,0,0,0,5'h0,8'h0,32'h0,5'd0,0,32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we",     rf_we, 1'b0);
        chk("rst_allowin",   ms_if.ws_allowin, 1'b1);
        chk("rst_flush",     ws_flush, 1'b0);
        chk("rst_flush_pc",  ws_flush_pc, E);
        chk("rst_cp0_bus",   ws_to_cp0_bus, '0);
        chk("rst_cp0_valid", ws_to_cp0_valid, 1'b0);
        chk("rst_mtc0_we",   ws_mtc0_we, 1'b0);
        chk("rst_dbg_pc",    debug_wb_pc, 32'h0);
        chk("rst_dbg_wen",   debug_wb_rf_wen, 4'h0);
        chk("rst_fwd_valid", ws_fwd_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive_ms(vecs[i].v, vecs[i].excp, vecs[i].eret, vecs[i].mfc0, vecs[i].mtc0, vecs[i].bd,
                     vecs[i].excode, vecs[i].addr, vecs[i].result, vecs[i].dest, vecs[i].gr_we, vecs[i].pc);
            @(posedge clk);
            #1;
            cp0_rdata_bus = vecs[i].rdata;
            cp0_EPC_bus   = vecs[i].epc;
            #1;
            chk($sformatf("v%0d_rf_we", i),     rf_we, vecs[i].e_rf_we);
            chk($sformatf("v%0d_rf_waddr", i),  rf_waddr, vecs[i].e_waddr);
            chk($sformatf("v%0d_rf_wdata", i),  rf_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d_cp0_valid", i), ws_to_cp0_valid, vecs[i].e_cp0v);
            chk($sformatf("v%0d_mtc0_we", i),   ws_mtc0_we, vecs[i].e_mtc);
            chk($sformatf("v%0d_flush", i),     ws_flush, vecs[i].e_flush);
            chk($sformatf("v%0d_flush_pc", i),  ws_flush_pc, vecs[i].e_fpc);
            chk($sformatf("v%0d_cp0_bus", i),   ws_to_cp0_bus,
                {vecs[i].e_eflush, vecs[i].e_caddr, vecs[i].e_cwdata, vecs[i].e_cexc, vecs[i].e_cpc, vecs[i].e_cbd});
            chk($sformatf("v%0d_dbg_pc", i),    debug_wb_pc, vecs[i].e_dpc);
            chk($sformatf("v%0d_dbg_wen", i),   debug_wb_rf_wen, {4{vecs[i].e_rf_we}});
            chk($sformatf("v%0d_dbg_wnum", i),  debug_wb_rf_wnum, vecs[i].e_waddr);
            chk($sformatf("v%0d_dbg_wdata", i), debug_wb_rf_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d_fwd_valid", i), ws_fwd_valid, vecs[i].e_rf_we);
            chk($sformatf("v%0d_fwd_dest", i),  ws_fwd_dest, vecs[i].e_waddr);
            chk($sformatf("v%0d_fwd_data", i),  ws_fwd_data, vecs[i].e_wdata);
            chk($sformatf("v%0d_allowin", i),   ms_if.ws_allowin, 1'b1);
        end

        // Reset while WS holds a valid GPR-writing instruction.
        @(negedge clk);
        cp0_rdata_bus = '0;
        cp0_EPC_bus   = '0;
        drive_ms(1,0,0,0,0,0,5'h0,8'h0,32'h4242,5'd6,1,32'hbfc00200);
        @(posedge clk);
        #1;
        chk("mid_rst_pre_rf_we", rf_we, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_rf_we",   rf_we, 1'b0);
        chk("mid_rst_flush",   ws_flush, 1'b0);
        chk("mid_rst_allowin", ms_if.ws_allowin, 1'b1);
        chk("mid_rst_dbg_pc",  debug_wb_pc, 32'h0);

        // Reset while an exception is committing.
        @(negedge clk);
        reset = 1'b0;
        drive_ms(1,1,0,0,0,0,5'h04,8'h0,32'h0,5'd0,0,32'hbfc00300);
        @(posedge clk);
        #1;
        chk("exc_rst_pre_flush", ws_flush, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("exc_rst_flush",     ws_flush, 1'b0);
        chk("exc_rst_cp0_valid", ws_to_cp0_valid, 1'b0);
        chk("exc_rst_flush_pc",  ws_flush_pc, E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 5-stage MIPS pipeline, between the memory stage (MS) and the register file and CP0.
- Latches one instruction per cycle from MS and retires it:
  - writes the GPR file, or
  - commits an exception, or
  - executes ERET.
- Drives the cp0 write/exception bus, the pipeline-wide flush with its redirect PC, WS->DS forwarding, and the debug trace.

Parameters:
- EXC_ENTRY, 32'hbfc00380, exception vector loaded into the fetch PC on exception commit.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- ms_to_ws_valid  in  1  MS holds a valid instruction
- ms_to_ws_bus  in  88  {cp0_addr[87:80], is_eret[79], is_mfc0[78], is_mtc0[77], bd[76], excode[75:71], excp[70], result[69:38], dest[37:33], gr_we[32], pc[31:0]}; for mtc0, result carries the rt value
- ws_allowin  out  1  WS accepts a new instruction this cycle
- cp0_rdata_bus  in  32  cp0 read data for the cp0_addr currently driven
- cp0_EPC_bus  in  32  current EPC
- ws_to_cp0_bus  out  79  {eret_flush[78], cp0_addr[77:70], cp0_wdata[69:38], excode[37:33], pc[32:1], bd[0]}
- ws_to_cp0_valid  out  1  exception commit strobe
- ws_mtc0_we  out  1  cp0 register write strobe
- ws_flush  out  1  clear all younger stages
- ws_flush_pc  out  32  fetch redirect target
- rf_we  out  1  GPR write enable
- rf_waddr  out  5  GPR write address
- rf_wdata  out  32  GPR write data
- ws_fwd_valid  out  1  forwarding entry valid
- ws_fwd_dest  out  5  forwarding destination register
- ws_fwd_data  out  32  forwarding data
- debug_wb_pc  out  32  trace PC
- debug_wb_rf_wen  out  4  trace byte write enables
- debug_wb_rf_wnum  out  5  trace register number
- debug_wb_rf_wdata  out  32  trace write data

Behaviour:
- Reset is synchronous, active-high, on clk.
  - ws_valid<=0 and the bus register <=0.
  - Consequently every output is 0 after reset except ws_allowin=1 and ws_flush_pc=EXC_ENTRY.
- Pipeline register:
  - ws_ready_go=1; ws_allowin = !ws_valid | ws_ready_go, i.e. constant 1.
  - Each cycle ws_valid <= ms_to_ws_valid & !ws_flush.
  - The bus register loads ms_to_ws_bus when ms_to_ws_valid & ws_allowin.
  - An instruction arriving in a flush cycle is dropped.
- Retire decode (all combinational from the registered fields, all gated by ws_valid):
  - exc = ws_valid & excp.
  - ert = ws_valid & is_eret & !excp.
  - mtc = ws_valid & is_mtc0 & !excp.
- GPR write:
  - rf_we = ws_valid & gr_we & !excp & !is_eret.
  - rf_waddr = dest.
  - rf_wdata = is_mfc0 ? cp0_rdata_bus : result.
- cp0 bus fields:
  - cp0_addr is always driven from the registered field, so the mfc0 read is same-cycle.
  - cp0_wdata = result; excode, pc and bd are passed through.
  - eret_flush = ert.
- cp0 strobes: ws_to_cp0_valid = exc; ws_mtc0_we = mtc.
- Exception has priority over eret and mtc0: an instruction with excp=1 never writes the GPR file or cp0 registers.
- Flush and redirect:
  - ws_flush = exc | ert, a one-cycle pulse for the single retiring instruction.
  - ws_flush_pc = exc ? EXC_ENTRY : (ert ? cp0_EPC_bus : EXC_ENTRY).
  - On eret, cp0_EPC_bus is sampled in the same cycle, before cp0 updates.
- Forwarding: ws_fwd_valid = rf_we; ws_fwd_dest = dest; ws_fwd_data = rf_wdata.
  - dest==0 is still reported; DS ignores r0.
- mtc0 followed by mfc0 to the same cp0 register needs no interlock: mtc0 writes at the end of its WS cycle, and mfc0 reads in the next cycle.
- Debug trace:
  - debug_wb_pc = pc when ws_valid, else 0.
  - debug_wb_rf_wen = {4{rf_we}}.
  - debug_wb_rf_wnum = dest; debug_wb_rf_wdata = rf_wdata.
- Back-to-back behaviour:
  - Consecutive valid instructions retire at one per cycle.
  - After a flush cycle, ws_valid is 0 for at least one cycle.
- Reset mid-operation: the in-flight WS instruction is discarded and produces no rf_we, strobe or flush.

Test Plan:
- ALU op stream:
  - Stimulus: pc=0xbfc00000, dest=3, gr_we=1, result=0x1234, valid three cycles in a row.
  - Required: rf_we=1, rf_waddr=3, rf_wdata=0x1234 one cycle after each accept; debug_wb_rf_wen=4'hf; ws_fwd mirrors the write.
- Exception commit:
  - Stimulus: excp=1, excode=5'h08, bd=1, pc=0xbfc00104, gr_we=1; ms_to_ws_valid=1 in the next cycle.
  - Required in the commit cycle: ws_to_cp0_valid=1, rf_we=0, ws_flush=1, ws_flush_pc=0xbfc00380, bus bd=1 and excode=8.
  - Required next cycle: the instruction sent in the flush cycle is dropped (ws_valid=0).
- ERET:
  - Stimulus: is_eret=1, cp0_EPC_bus=0xbfc00200.
  - Required: eret_flush bit=1, ws_flush=1, ws_flush_pc=0xbfc00200, ws_to_cp0_valid=0, rf_we=0.
- mtc0 then mfc0:
  - Stimulus: mtc0 with cp0_addr=8'h60 (Status), result=0x0000ff01; then mfc0 with addr 8'h60, dest=4.
  - Required: ws_mtc0_we=1 for exactly one cycle; in the next cycle rf_wdata=cp0_rdata_bus, rf_waddr=4.
- mtc0 with excp=1 -> ws_mtc0_we=0, ws_to_cp0_valid=1.
- Reset asserted while WS holds a valid gr_we instruction -> the next cycle shows rf_we=0, ws_flush=0, ws_allowin=1.
